// File: rtl/cpu_pkg.sv
// Shared fetch-stage types, opcode constants and byte-mask helper.
package cpu_pkg;

  typedef logic [2:0] len_t;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    FETCH_HI = 2'd1,
    EMIT     = 2'd2,
    HALT     = 2'd3
  } fetch_state_e;

  localparam logic [7:0] OP_ADD_RM    = 8'h01;
  localparam logic [7:0] OP_PUSH_EAX  = 8'h50;
  localparam logic [7:0] OP_PUSH_EBX  = 8'h53;
  localparam logic [7:0] OP_PUSH_EBP  = 8'h55;
  localparam logic [7:0] OP_POP_EBP   = 8'h5D;
  localparam logic [7:0] OP_PUSH_IMM8 = 8'h6A;
  localparam logic [7:0] OP_JE        = 8'h74;
  localparam logic [7:0] OP_JNE       = 8'h75;
  localparam logic [7:0] OP_GRP1_IMM8 = 8'h83;
  localparam logic [7:0] OP_TEST_RM   = 8'h85;
  localparam logic [7:0] OP_MOV_RM    = 8'h89;
  localparam logic [7:0] OP_MOV_MR    = 8'h8B;
  localparam logic [7:0] OP_MOV_IMM   = 8'hB8;
  localparam logic [7:0] OP_RET       = 8'hC3;
  localparam logic [7:0] OP_LEAVE     = 8'hC9;
  localparam logic [7:0] OP_CALL      = 8'hE8;
  localparam logic [7:0] OP_JMP_SHORT = 8'hEB;

  localparam logic [1:0] MOD_REG  = 2'b11;
  localparam logic [1:0] MOD_DISP8 = 2'b01;

  // Left-aligned mask keeping the first len bytes of a 5-byte slot.
  function automatic logic [39:0] byte_mask(input len_t len);
    logic [39:0] m;
    m = '0;
    case (len)
      3'd1:    m = 40'hFF_0000_0000;
      3'd2:    m = 40'hFF_FF00_0000;
      3'd3:    m = 40'hFF_FFFF_0000;
      3'd4:    m = 40'hFF_FFFF_FF00;
      3'd5:    m = 40'hFF_FFFF_FFFF;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/x86_len_decode.sv
// Combinational x86-subset length decoder: opcode + ModRM -> length / illegal.
import cpu_pkg::*;

module x86_len_decode (
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  output len_t       len,
  output logic       illegal
);

  logic [1:0] mod;
  assign mod = b1[7:6];

  // Length lookup; unsupported forms report illegal with length 1.
  always_comb begin
    len     = 3'd1;
    illegal = 1'b0;
    case (b0)
      OP_PUSH_EAX, OP_PUSH_EBX, OP_PUSH_EBP, OP_POP_EBP, OP_RET, OP_LEAVE:
        len = 3'd1;
      OP_PUSH_IMM8, OP_JE, OP_JNE, OP_JMP_SHORT:
        len = 3'd2;
      OP_ADD_RM, OP_TEST_RM, OP_MOV_RM, OP_MOV_MR: begin
        if (mod == MOD_REG)        len = 3'd2;
        else if (mod == MOD_DISP8) len = 3'd3;
        else                       illegal = 1'b1;
      end
      OP_GRP1_IMM8: begin
        if (mod == MOD_REG)        len = 3'd3;
        else if (mod == MOD_DISP8) len = 3'd4;
        else                       illegal = 1'b1;
      end
      OP_CALL:
        len = 3'd5;
      default: begin
        if (b0[7:3] == OP_MOV_IMM[7:3]) len = 3'd5;
        else                            illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch / length-decode stage with valid/ready hand-off and redirects.
import cpu_pkg::*;

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0050,
  parameter logic [31:0] MEM_TOP  = 32'd128
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] addr,
  input  logic [31:0] ope,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [39:0] inst_bytes,
  output logic [2:0]  inst_len,
  output logic [31:0] inst_pc,
  output logic        inst_illegal,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state;
  logic [31:0]  pc;
  len_t         dec_len;
  logic         dec_illegal;
  logic [31:0]  last_byte;
  logic         dec_fault;

  x86_len_decode u_len_decode (
    .b0      (ope[31:24]),
    .b1      (ope[23:16]),
    .len     (dec_len),
    .illegal (dec_illegal)
  );

  assign last_byte  = pc + {29'd0, dec_len} - 32'd1;
  assign dec_fault  = last_byte > MEM_TOP;
  assign addr       = (state == FETCH_HI) ? pc + 32'd4 : pc;
  assign inst_valid = (state == EMIT);

  // Fetch sequencer; the payload registers double as the assembly buffer,
  // so they stay frozen throughout EMIT until acceptance or redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      inst_bytes   <= '0;
      inst_len     <= '0;
      inst_pc      <= '0;
      inst_illegal <= 1'b0;
      inst_fault   <= 1'b0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          inst_bytes   <= {ope, 8'h00} & byte_mask(dec_len);
          inst_len     <= dec_len;
          inst_pc      <= pc;
          inst_illegal <= dec_illegal;
          inst_fault   <= dec_fault;
          state        <= (dec_len == 3'd5 && !dec_illegal) ? FETCH_HI : EMIT;
        end
        FETCH_HI: begin
          inst_bytes[7:0] <= ope[31:24];
          state           <= EMIT;
        end
        EMIT: begin
          if (inst_ready) begin
            pc    <= pc + {29'd0, inst_len};
            state <= inst_illegal ? HALT : FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory image model, expected-instruction queue.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] ope;
  logic        inst_valid;
  logic        inst_ready;
  logic [39:0] inst_bytes;
  logic [2:0]  inst_len;
  logic [31:0] inst_pc;
  logic        inst_illegal;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  len;
    logic [39:0] bytes;
    logic        ill;
    logic        flt;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  assign ope = {mem[addr[7:0]], mem[8'(addr[7:0] + 8'd1)],
                mem[8'(addr[7:0] + 8'd2)], mem[8'(addr[7:0] + 8'd3)]};

  instr_fetch #(.RESET_PC(32'h0000_0050), .MEM_TOP(32'd128)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .addr           (addr),
    .ope            (ope),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_bytes     (inst_bytes),
    .inst_len       (inst_len),
    .inst_pc        (inst_pc),
    .inst_illegal   (inst_illegal),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [2:0] len,
                          input logic [39:0] bytes, input logic ill, input logic flt);
    exp_t e;
    e.pc = pc; e.len = len; e.bytes = bytes; e.ill = ill; e.flt = flt;
    sb.push_back(e);
  endtask

  // Sampling point: just after the falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Drive point: just after the rising edge.
  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (n_acc < target && n < budget) begin
      cyc();
      n++;
    end
    check_eq("wait_acc", 64'(n_acc), 64'(target));
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!inst_valid && n < budget) begin
      cyc();
      n++;
    end
    check_eq("wait_valid", 64'(inst_valid), 64'd1);
  endtask

  // Handshake monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("sb_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_pc",      64'(inst_pc),      64'(e.pc));
        check_eq("sb_len",     64'(inst_len),     64'(e.len));
        check_eq("sb_bytes",   64'(inst_bytes),   64'(e.bytes));
        check_eq("sb_illegal", 64'(inst_illegal), 64'(e.ill));
        check_eq("sb_fault",   64'(inst_fault),   64'(e.flt));
      end
      n_acc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // fib-style image
    mem[8'h50] = 8'h55;
    mem[8'h51] = 8'h89; mem[8'h52] = 8'hE5;
    mem[8'h53] = 8'h83; mem[8'h54] = 8'hEC; mem[8'h55] = 8'h18;
    mem[8'h56] = 8'h89; mem[8'h57] = 8'h45; mem[8'h58] = 8'hFC;
    mem[8'h59] = 8'h85; mem[8'h5A] = 8'hC0;
    mem[8'h5B] = 8'hE8; mem[8'h5C] = 8'hA0; mem[8'h5D] = 8'hFF; mem[8'h5E] = 8'hFF; mem[8'h5F] = 8'hFF;
    mem[8'h60] = 8'h83; mem[8'h61] = 8'hC4; mem[8'h62] = 8'h10;
    mem[8'h63] = 8'h89; mem[8'h64] = 8'hC3;
    mem[8'h65] = 8'h53;
    mem[8'h66] = 8'h8B; mem[8'h67] = 8'h45; mem[8'h68] = 8'hF4;
    mem[8'h69] = 8'h5D;
    mem[8'h6A] = 8'hC9;
    mem[8'h6B] = 8'hC3;
    mem[8'h6C] = 8'hEB; mem[8'h6D] = 8'hFE;
    mem[8'h6E] = 8'hB8; mem[8'h6F] = 8'h11; mem[8'h70] = 8'h22; mem[8'h71] = 8'h33; mem[8'h72] = 8'h44;
    mem[8'h00] = 8'h55; mem[8'h01] = 8'hAA; mem[8'h02] = 8'hBB;
    mem[8'h10] = 8'h0F; mem[8'h11] = 8'h12; mem[8'h12] = 8'h34;
    mem[8'h7E] = 8'hB8; mem[8'h7F] = 8'h01; mem[8'h80] = 8'h02; mem[8'h81] = 8'h03; mem[8'h82] = 8'h04;

    reset_n        = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    cyc();
    cyc();
    check_eq("rst_valid",   64'(inst_valid),   64'd0);
    check_eq("rst_bytes",   64'(inst_bytes),   64'd0);
    check_eq("rst_len",     64'(inst_len),     64'd0);
    check_eq("rst_pc",      64'(inst_pc),      64'd0);
    check_eq("rst_illegal", 64'(inst_illegal), 64'd0);
    check_eq("rst_fault",   64'(inst_fault),   64'd0);
    check_eq("rst_addr",    64'(addr),         64'h50);

    push_exp(32'h50, 3'd1, 40'h55_0000_0000, 1'b0, 1'b0);
    push_exp(32'h51, 3'd2, 40'h89_E500_0000, 1'b0, 1'b0);
    push_exp(32'h53, 3'd3, 40'h83_EC18_0000, 1'b0, 1'b0);
    push_exp(32'h56, 3'd3, 40'h89_45FC_0000, 1'b0, 1'b0);
    push_exp(32'h59, 3'd2, 40'h85_C000_0000, 1'b0, 1'b0);
    push_exp(32'h5B, 3'd5, 40'hE8_A0FF_FFFF, 1'b0, 1'b0);
    push_exp(32'h60, 3'd3, 40'h83_C410_0000, 1'b0, 1'b0);
    push_exp(32'h63, 3'd2, 40'h89_C300_0000, 1'b0, 1'b0);
    push_exp(32'h65, 3'd1, 40'h53_0000_0000, 1'b0, 1'b0);
    push_exp(32'h66, 3'd3, 40'h8B_45F4_0000, 1'b0, 1'b0);
    push_exp(32'h69, 3'd1, 40'h5D_0000_0000, 1'b0, 1'b0);
    push_exp(32'h6A, 3'd1, 40'hC9_0000_0000, 1'b0, 1'b0);
    push_exp(32'h6B, 3'd1, 40'hC3_0000_0000, 1'b0, 1'b0);
    push_exp(32'h6C, 3'd2, 40'hEB_FE00_0000, 1'b0, 1'b0);

    reset_n = 1'b1;
    cyc();
    check_eq("lat_first_valid", 64'(inst_valid), 64'd1);

    // 5-byte call: two window reads
    wait_acc(5, 40);
    cyc();
    check_eq("call_addr_lo", 64'(addr), 64'h5B);
    check_eq("call_valid_lo", 64'(inst_valid), 64'd0);
    cyc();
    check_eq("call_addr_hi", 64'(addr), 64'h5F);
    check_eq("call_valid_hi", 64'(inst_valid), 64'd0);
    cyc();
    check_eq("call_valid", 64'(inst_valid), 64'd1);

    // Back-pressure on 8B 45 F4
    wait_acc(9, 40);
    post_edge();
    inst_ready = 1'b0;
    check_eq("stall_fetch_addr", 64'(addr), 64'h66);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", 64'(inst_valid), 64'd1);
      check_eq("stall_bytes", 64'(inst_bytes), 64'h8B_45F4_0000);
      check_eq("stall_len",   64'(inst_len),   64'd3);
      check_eq("stall_pc",    64'(inst_pc),    64'h66);
      check_eq("stall_addr",  64'(addr),       64'h66);
      cyc();
    end
    post_edge();
    inst_ready = 1'b1;

    // Redirect during the second window read of B8 at 0x6E
    wait_acc(14, 40);
    post_edge();
    check_eq("mov_addr_lo", 64'(addr), 64'h6E);
    post_edge();
    check_eq("mov_addr_hi", 64'(addr), 64'h72);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    post_edge();
    redirect_valid = 1'b0;
    check_eq("redir_drop_valid", 64'(inst_valid), 64'd0);
    check_eq("redir_addr", 64'(addr), 64'h0);
    push_exp(32'h00, 3'd1, 40'h55_0000_0000, 1'b0, 1'b0);
    wait_valid(10);

    // Redirect coinciding with acceptance of 0x00 sends fetch to 0x10
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    post_edge();
    redirect_valid = 1'b0;
    check_eq("redir2_drop_valid", 64'(inst_valid), 64'd0);
    check_eq("redir2_addr", 64'(addr), 64'h10);
    check_eq("redir2_acc", 64'(n_acc), 64'd15);
    push_exp(32'h10, 3'd1, 40'h0F_0000_0000, 1'b1, 1'b0);
    wait_valid(10);
    check_eq("ill_flag", 64'(inst_illegal), 64'd1);
    check_eq("ill_len",  64'(inst_len),     64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("halt_valid", 64'(inst_valid), 64'd0);
      check_eq("halt_addr",  64'(addr),       64'h11);
    end

    // Resume from HALT at 0x50, then redirect to 0x7E on acceptance
    push_exp(32'h50, 3'd1, 40'h55_0000_0000, 1'b0, 1'b0);
    post_edge();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h50;
    post_edge();
    redirect_valid = 1'b0;
    wait_valid(10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7E;
    post_edge();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    wait_valid(10);
    check_eq("flt_fault",   64'(inst_fault),   64'd1);
    check_eq("flt_len",     64'(inst_len),     64'd5);
    check_eq("flt_pc",      64'(inst_pc),      64'h7E);
    check_eq("flt_bytes",   64'(inst_bytes),   64'hB8_0102_0304);
    check_eq("flt_illegal", 64'(inst_illegal), 64'd0);

    // Asynchronous reset in the middle of EMIT
    reset_n = 1'b0;
    #1;
    check_eq("mrst_valid",   64'(inst_valid),   64'd0);
    check_eq("mrst_bytes",   64'(inst_bytes),   64'd0);
    check_eq("mrst_len",     64'(inst_len),     64'd0);
    check_eq("mrst_pc",      64'(inst_pc),      64'd0);
    check_eq("mrst_illegal", 64'(inst_illegal), 64'd0);
    check_eq("mrst_fault",   64'(inst_fault),   64'd0);
    check_eq("mrst_addr",    64'(addr),         64'h50);
    cyc();
    check_eq("acc_total",  64'(n_acc),     64'd17);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and length-decode stage sitting directly downstream of `program_memory`. Drives the byte address into the memory, captures its 32-bit big-endian window (`ope[31:24]` = byte at `addr`), and determines the x86-subset instruction length. Assembles instructions of up to 5 bytes, using a second window read when needed, and hands each instruction to the execute stage over a valid/ready handshake. Accepts control-flow redirects (jmp/jcc/call/ret) from execute.

## Interface
- `RESET_PC`, default 32'h0000_0050: fetch address after reset.
- `MEM_TOP`, default 32'd128: highest valid byte address. Any byte past it raises a fault.
- `clk`  in  1: clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset. One clock domain only.
- `addr`  out  32: byte address to `program_memory`. Combinational from state.
- `ope`  in  32: memory window, bytes `addr`..`addr+3`, MSB first. Combinational.
- `inst_valid`  out  1: instruction available.
- `inst_ready`  in  1: execute accepts the instruction.
- `inst_bytes`  out  40: instruction bytes left-aligned; `[39:32]` is the opcode; unused bytes are 0.
- `inst_len`  out  3: length, 1..5.
- `inst_pc`  out  32: address of the opcode byte.
- `inst_illegal`  out  1: opcode or ModRM form not supported.
- `inst_fault`  out  1: `inst_pc+inst_len-1 > MEM_TOP`.
- `redirect_valid`  in  1: execute requests a new PC.
- `redirect_pc`  in  32: target address.

## Operation
- Length rules (b0 = opcode, b1 = ModRM, mod = b1[7:6]):
  - 1 byte: 50, 53, 55, 5D, C3, C9.
  - 2 bytes: 6A, 74, 75, EB.
  - 01/85/89/8B: mod=11 gives 2, mod=01 gives 3. Any other mod is illegal.
  - 83: mod=11 gives 3, mod=01 gives 4. Any other mod is illegal.
  - B8–BF and E8 give 5.
  - Anything else is illegal, with length 1.
- States:
  - FETCH:
    - `addr=pc`.
    - Capture `ope` into `buf[39:8]` and decode.
    - If length ≤ 4 or illegal: go to EMIT.
    - If length = 5: go to FETCH_HI.
  - FETCH_HI:
    - `addr=pc+4`.
    - Capture `ope[31:24]` into `buf[7:0]`.
    - Go to EMIT.
  - EMIT:
    - `inst_valid=1`. Outputs are held stable.
    - `addr=pc`.
    - On `inst_ready`: `pc <= pc+inst_len`.
      - If illegal: go to HALT.
      - Otherwise: go to FETCH.
  - HALT:
    - `inst_valid=0`. Stays here until a redirect.
- Byte masking: bytes beyond `inst_len` are zeroed in `inst_bytes`.
- Redirect:
  - `redirect_valid` in any state sets `pc <= redirect_pc` and next state FETCH.
  - Any pending or partial instruction is discarded.
  - `inst_valid` drops the next cycle.
  - Redirect wins over a simultaneous `inst_valid && inst_ready`; the handshake still counts as accepted.
- Fault: `inst_fault` is computed in the decode cycle. The instruction is still emitted; the fetch stage continues and does not halt.
- Address arithmetic: 32-bit, wraps modulo 2^32. `pc+4` also wraps.

## Timing
- Reset values:
  - `pc=RESET_PC`, state FETCH.
  - `inst_valid=0`, `inst_bytes=0`, `inst_len=0`, `inst_pc=0`, `inst_illegal=0`, `inst_fault=0`.
  - `addr=RESET_PC` during reset.
- Latency, 1–4 byte instruction: `inst_valid` rises 1 cycle after entering FETCH.
- Latency, 5-byte instruction: `inst_valid` rises 2 cycles after entering FETCH.
- Best-case throughput (`inst_ready` tied high): one instruction per 2 cycles (≤4 bytes) or per 3 cycles (5 bytes).
- Handshake rules:
  - Once `inst_valid` is asserted, it and all payload outputs hold until accepted or redirected.
  - `inst_ready` may toggle freely.
- Reset mid-operation: immediate return to reset values. No partial instruction survives.

## Structure
- Package `cpu_pkg` holds:
  - Fetch state enum (FETCH, FETCH_HI, EMIT, HALT).
  - Opcode constants (OP_PUSH_EBP = 8'h55, OP_CALL = 8'hE8, OP_MOV_IMM = 8'hB8, …).
  - 3-bit length type.
- Sub-module `x86_len_decode`: purely combinational; takes b0 and b1, returns length and illegal. Instantiated once.

## Test plan
- Reset with the fib image loaded and `inst_ready`=1:
  - PCs must be 0x50, 0x51, 0x53, 0x56, 0x59, 0x5B.
  - Lengths must be 1, 2, 3, 3, 2, 5.
  - `inst_bytes` at 0x53 = 40'h83EC180000.
- E8 A0 FF FF FF at 0x5B:
  - `addr` = 0x5B, then 0x5F.
  - `inst_bytes` = 40'hE8A0FFFFFF, `inst_len` = 5.
  - Next PC = 0x60.
- Hold `inst_ready`=0 for 5 cycles on 8B 45 F4 at 0x66:
  - `inst_valid` and payload stay constant; `pc` is unchanged.
  - On release, next PC = 0x69.
- Assert `redirect_valid` with `redirect_pc`=0x00 while in FETCH_HI:
  - The partial instruction is dropped.
  - The next instruction is 55 at PC 0x00 with length 1.
- Opcode 0x0F at 0x10:
  - `inst_illegal`=1, `inst_len`=1.
  - After acceptance, HALT with `inst_valid`=0 until a redirect to 0x50 resumes fetch.
- Redirect to 0x7E with B8 there:
  - `inst_fault`=1, because 0x7E+4 = 0x82 > 128.
  - Deassert `reset_n` mid-EMIT: outputs return to reset values and `addr`=0x50.
